// File: rtl/bus_pkg.sv
// Shared definitions for the SoC data-bus targets: op codes, FSM encoding, bus width.
package bus_pkg;

    localparam int unsigned BusW = 32;

    // RISC-V load/store funct3 codes
    localparam logic [2:0] OP_B  = 3'd0;
    localparam logic [2:0] OP_H  = 3'd1;
    localparam logic [2:0] OP_W  = 3'd2;
    localparam logic [2:0] OP_BU = 3'd4;
    localparam logic [2:0] OP_HU = 3'd5;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StResp   = 2'b10,
        StDone   = 2'b11
    } state_e;

endpackage

// File: rtl/lane_align.sv
// Combinational byte-lane steering: store byte-enables/lane-replicated data and
// load extraction with sign or zero extension.
module lane_align
    import bus_pkg::*;
(
    input  logic [2:0]      mem_op_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [BusW-1:0] wdata_i,
    input  logic [BusW-1:0] rword_i,
    output logic [3:0]      be_o,
    output logic [BusW-1:0] wword_o,
    output logic [BusW-1:0] rdata_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign ld_half = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    // Store lanes: data is replicated into every lane, the enables pick the live ones
    always_comb begin
        be_o    = 4'b1111;
        wword_o = wdata_i;
        case (mem_op_i)
            OP_B, OP_BU: begin
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
            end
            OP_H, OP_HU: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wword_o = wdata_i;
            end
        endcase
    end

    // Load extraction; undefined codes fall through to a full word
    always_comb begin
        rdata_o = rword_i;
        case (mem_op_i)
            OP_B:    rdata_o = {{24{ld_byte[7]}}, ld_byte};
            OP_BU:   rdata_o = {24'h0, ld_byte};
            OP_H:    rdata_o = {{16{ld_half[15]}}, ld_half};
            OP_HU:   rdata_o = {16'h0, ld_half};
            default: rdata_o = rword_i;
        endcase
    end

endmodule

// File: rtl/bus_sram_target.sv
// SRAM-backed bus target: one request at a time, optional wait states, a single
// ready pulse per request and zero outputs otherwise so the return bus can be OR-ed.
module bus_sram_target
    import bus_pkg::*;
#(
    parameter int unsigned AW          = 12,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            sel_i,
    input  logic [31:0]     addr_i,
    input  logic [2:0]      mem_op_i,
    input  logic            we_i,
    input  logic            re_i,
    input  logic [BusW-1:0] wdata_i,
    output logic [BusW-1:0] rdata_o,
    output logic            ready_o
);

    localparam int unsigned Depth = 1 << AW;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AW+1:0]     addr_q, addr_d;
    logic [2:0]        op_q, op_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [BusW-1:0]   wdata_q, wdata_d;
    logic [BusW-1:0]   rword_q;
    logic [BusW-1:0]   mem_q [Depth];

    logic              fire;
    logic              rd_en;
    logic [3:0]        be;
    logic [BusW-1:0]   wword;
    logic [BusW-1:0]   ld_data;
    logic              unused_addr;

    // Upper address bits are ignored so the array wraps
    assign unused_addr = ^addr_i[31:AW+2];

    assign fire  = (state_q == StAccess) && (cnt_q == 4'd0);
    assign rd_en = re_q & ~we_q;

    lane_align u_lane_align (
        .mem_op_i  (op_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rword_i   (rword_q),
        .be_o      (be),
        .wword_o   (wword),
        .rdata_o   (ld_data)
    );

    // Next-state: requests are only sampled in idle; done waits for sel to drop
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        op_d    = op_q;
        we_d    = we_q;
        re_d    = re_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (sel_i) begin
                    state_d = StAccess;
                    cnt_d   = 4'(WAIT_STATES);
                    addr_d  = addr_i[AW+1:0];
                    op_d    = mem_op_i;
                    we_d    = we_i;
                    re_d    = re_i;
                    wdata_d = wdata_i;
                end
            end
            StAccess: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StResp;
                end
            end
            StResp: state_d = StDone;
            StDone: begin
                if (!sel_i) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // FSM state and latched request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            op_q    <= 3'd0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            we_q    <= we_d;
            re_q    <= re_d;
            wdata_q <= wdata_d;
        end
    end

    // Single-port RAM with byte enables; contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (fire && we_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[addr_q[AW+1:2]][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
        if (fire && rd_en) begin
            rword_q <= mem_q[addr_q[AW+1:2]];
        end
    end

    // Outputs are gated by registered state only, so they are zero outside the pulse
    always_comb begin
        ready_o = (state_q == StResp);
        rdata_o = (ready_o && rd_en) ? ld_data : '0;
    end

endmodule
